csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Parametrised machine-mode CSR file, successor to the core's single-CSR regfile path.
//  Holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mhartid plus free-running mcycle/minstret.
//  Provides CSR RW/RS/RC access, trap-entry and mret sequencing.
//  Sits beside the GPR file; EX stage drives it, and difftest taps it.
// PARAMETERS
//  XLEN         64  datapath width, 32 or 64; counters are always 64 bit
//  HART_ID      0   value returned by mhartid (0xF14)
//  MTVEC_RESET  0   mtvec reset value
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous reset, active-high
//  csr_addr     in   12    CSR address
//  csr_op       in   2     00 none, 01 RW, 10 RS, 11 RC
//  csr_wdata    in   XLEN  write/set/clear operand
//  csr_rdata    out  XLEN  old value of csr_addr (combinational)
//  csr_illegal  out  1     op!=00 and (unmapped addr, or write to read-only)
//  instret_inc  in   1     one instruction retired this cycle
//  trap_valid   in   1     take trap this cycle
//  trap_pc      in   XLEN  pc of trapping instruction
//  trap_cause   in   XLEN  mcause value; MSB = interrupt
//  trap_vec     out  XLEN  trap target pc (combinational)
//  mret_valid   in   1     execute mret this cycle
//  mret_pc      out  XLEN  current mepc (combinational)
//  mstatus_o    out  XLEN  current mstatus, for difftest
//  mcycle_o     out  64    current mcycle, for difftest
// BEHAVIOUR
//  Reset: all CSRs 0 except mtvec=MTVEC_RESET, mstatus.MPP=2'b11; csr_rdata=0, csr_illegal=0.
//  Read: csr_rdata = pre-write value, same cycle.
//  Read: op==00 or illegal -> csr_rdata=0.
//  Write: at the next posedge; new = RW:wdata, RS:old|wdata, RC:old&~wdata.
//  Write: RS/RC with wdata==0 leaves the value unchanged.
//  Read-only: mhartid reads HART_ID.
//  Read-only: RW to mhartid -> csr_illegal=1 and no state change.
//  Read-only: RS/RC to mhartid with wdata==0 is legal.
//  Illegal: unmapped address -> illegal, no state change.
//  Illegal: XLEN=64 access to 0xB80/0xB82 is unmapped.
//  Write masks: mepc[1:0] and mtvec[1] always read 0.
//  Write masks: mstatus writable bits are only MIE(3), MPIE(7), MPP(12:11).
//  Write masks: MPP reads 2'b11 regardless of writes.
//  Counters: mcycle +1 every cycle; minstret +1 when instret_inc.
//  Counters: wrap 2^64-1 -> 0.
//  Counters: CSR write to a counter (or its high half) that cycle wins, with no increment.
//  XLEN=32: 0xB00/0xB02 are the low halves; 0xB80/0xB82 (mcycleh/minstreth) are the high halves.
//  XLEN=32: a low-half write leaves the high half unchanged, and vice versa.
//  Trap (trap_valid): mepc <= {trap_pc[XLEN-1:2],2'b00}; mcause <= trap_cause.
//  Trap (trap_valid): MPIE <= MIE; MIE <= 0.
//  mret (mret_valid): MIE <= MPIE; MPIE <= 1.
//  trap_vec: mtvec[0]==0 -> {mtvec[XLEN-1:2],2'b00}.
//  trap_vec: mtvec[0]==1 and cause MSB set -> base + 4*cause[XLEN-2:0].
//  Priority: trap > mret > CSR op. A suppressed op writes nothing; counters still tick.
//  Priority: csr_illegal is still reported for a suppressed op.
//  rst asserted mid-operation: reset wins over all inputs that cycle.
// STRUCTURE
//  csr_defines.v: CSR address localparams, op encodings, mstatus bit indices.
//  csr_defines.v: mtvec mode encoding.
//  Sub-module csr_counter64: 64-bit counter with inc, wr_lo, wr_hi, wdata.
//  csr_counter64 is instanced twice (mcycle, minstret).
// TESTING
//  1. Reset, then read 0x300/0x305/0xF14 -> 0x1800 / MTVEC_RESET / HART_ID; illegal=0.
//  2. RW 0x340 <= 0xA5; RS 0x340 wdata=0x0F -> rdata 0xA5; then read -> 0xAF.
//  3. RC 0x340 wdata=0xA0 -> next read 0x0F.
//  4. RW 0xF14 -> illegal=1, value unchanged.
//  5. Read 0x7C0 -> illegal=1, rdata=0.
//  6. MIE=1, trap_valid, trap_pc=0x80000006, cause=0xB -> mepc=0x80000004, mcause=0xB.
//     Expect MIE=0, MPIE=1; then mret -> MIE=1, mret_pc=0x80000004.
//  7. mtvec=0x80000001, cause=0x8000000000000007 -> trap_vec=0x8000001C.
//  8. RW mcycle=0xFFFFFFFFFFFFFFFF -> reads 0 two cycles later.
//  9. Hold instret_inc 5 cycles -> minstret=5; RW minstret with instret_inc=1 -> written value.
// 10. XLEN=32: RW 0xB80=1 -> mcycle_o[63:32]=1, low half unchanged.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, access ops,
// mstatus bit positions, mtvec modes and the RW/RS/RC update rule.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic {
    MTVEC_DIRECT   = 1'b0,
    MTVEC_VECTORED = 1'b1
  } mtvec_mode_e;

  function automatic logic [63:0] csr_apply(input csr_op_e op,
                                            input logic [63:0] old_val,
                                            input logic [63:0] operand);
    case (op)
      CSR_OP_RW: csr_apply = operand;
      CSR_OP_RS: csr_apply = old_val | operand;
      CSR_OP_RC: csr_apply = old_val & ~operand;
      default:   csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// Any write that cycle suppresses the increment, so a written value is seen verbatim.
module csr_file_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wdata,
  output logic [63:0] count
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;
  logic [63:0] cnt_inc;
  logic [1:0]  wr_half;

  assign wr_half = {wr_hi, wr_lo};
  assign cnt_inc = (inc && !(|wr_half)) ? cnt_q + 64'd1 : cnt_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign cnt_d[32*gi +: 32] = wr_half[gi] ? wdata[32*gi +: 32] : cnt_inc[32*gi +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR RW/RS/RC access, trap entry, mret, and the
// mcycle/minstret counters (split into halves when XLEN is 32).
module csr_file
  import csr_file_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            instret_inc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_vec,
  input  logic            mret_valid,
  output logic [XLEN-1:0] mret_pc,
  output logic [XLEN-1:0] mstatus_o,
  output logic [63:0]     mcycle_o
);

  localparam bit HAS_HI = (XLEN == 32);

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic            ms_mie_q, ms_mie_d;
  logic            ms_mpie_q, ms_mpie_d;
  logic [XLEN-1:0] mie_csr_q, mie_csr_d;
  logic [XLEN-1:0] mip_csr_q, mip_csr_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [63:0]     mcycle;
  logic [63:0]     minstret;
  logic [XLEN-1:0] mstatus_val;
  logic [63:0]     rd_raw;
  logic [63:0]     new_val;
  logic [XLEN-1:0] new_x;
  logic [63:0]     cnt_wdata;
  logic            mapped;
  logic            read_only;
  logic            do_write;
  logic            illegal;
  logic            wr_en;
  logic            cyc_wr_lo, cyc_wr_hi;
  logic            ins_wr_lo, ins_wr_hi;
  logic [XLEN-1:0] tv_base;
  logic            unused_trap_pc_lsbs;

  // Only MIE and MPIE are stored; MPP is hardwired to machine mode.
  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE] = ms_mie_q;
    mstatus_val[MSTATUS_MPIE] = ms_mpie_q;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    rd_raw    = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:  rd_raw = 64'(mstatus_val);
      CSR_MIE:      rd_raw = 64'(mie_csr_q);
      CSR_MIP:      rd_raw = 64'(mip_csr_q);
      CSR_MTVEC:    rd_raw = 64'(mtvec_q);
      CSR_MSCRATCH: rd_raw = 64'(mscratch_q);
      CSR_MEPC:     rd_raw = 64'(mepc_q);
      CSR_MCAUSE:   rd_raw = 64'(mcause_q);
      CSR_MCYCLE:   rd_raw = 64'(mcycle[XLEN-1:0]);
      CSR_MINSTRET: rd_raw = 64'(minstret[XLEN-1:0]);
      CSR_MCYCLEH: begin
        if (HAS_HI) rd_raw = {32'h0, mcycle[63:32]};
        else        mapped = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (HAS_HI) rd_raw = {32'h0, minstret[63:32]};
        else        mapped = 1'b0;
      end
      CSR_MHARTID: begin
        rd_raw    = 64'(HART_ID);
        read_only = 1'b1;
      end
      default: mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read: nothing is written.
  assign do_write    = (op == CSR_OP_RW) || (csr_wdata != '0);
  assign illegal     = (op != CSR_OP_NONE) && (!mapped || (read_only && do_write));
  assign csr_illegal = illegal && !rst;
  assign csr_rdata   = (op == CSR_OP_NONE || illegal || rst) ? '0 : rd_raw[XLEN-1:0];
  assign wr_en       = (op != CSR_OP_NONE) && !illegal && do_write && !trap_valid && !mret_valid;

  assign new_val   = csr_apply(op, rd_raw, 64'(csr_wdata));
  assign new_x     = new_val[XLEN-1:0];
  assign cnt_wdata = HAS_HI ? {new_val[31:0], new_val[31:0]} : new_val;

  assign cyc_wr_lo = wr_en && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = wr_en && (csr_addr == (HAS_HI ? CSR_MCYCLEH : CSR_MCYCLE));
  assign ins_wr_lo = wr_en && (csr_addr == CSR_MINSTRET);
  assign ins_wr_hi = wr_en && (csr_addr == (HAS_HI ? CSR_MINSTRETH : CSR_MINSTRET));

  always_comb begin
    ms_mie_d   = ms_mie_q;
    ms_mpie_d  = ms_mpie_q;
    mie_csr_d  = mie_csr_q;
    mip_csr_d  = mip_csr_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_valid) begin
      mepc_d    = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d  = trap_cause;
      ms_mpie_d = ms_mie_q;
      ms_mie_d  = 1'b0;
    end else if (mret_valid) begin
      ms_mie_d  = ms_mpie_q;
      ms_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          ms_mie_d  = new_x[MSTATUS_MIE];
          ms_mpie_d = new_x[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_csr_d  = new_x;
        CSR_MIP:      mip_csr_d  = new_x;
        CSR_MTVEC:    mtvec_d    = {new_x[XLEN-1:2], 1'b0, new_x[0]};
        CSR_MSCRATCH: mscratch_d = new_x;
        CSR_MEPC:     mepc_d     = {new_x[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = new_x;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ms_mie_q   <= 1'b0;
      ms_mpie_q  <= 1'b0;
      mie_csr_q  <= '0;
      mip_csr_q  <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      ms_mie_q   <= ms_mie_d;
      ms_mpie_q  <= ms_mpie_d;
      mie_csr_q  <= mie_csr_d;
      mip_csr_q  <= mip_csr_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_file_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (cnt_wdata),
    .count (mcycle)
  );

  csr_file_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_inc),
    .wr_lo (ins_wr_lo),
    .wr_hi (ins_wr_hi),
    .wdata (cnt_wdata),
    .count (minstret)
  );

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  always_comb begin
    tv_base  = {mtvec_q[XLEN-1:2], 2'b00};
    trap_vec = tv_base;
    if (mtvec_mode_e'(mtvec_q[0]) == MTVEC_VECTORED && trap_cause[XLEN-1]) begin
      trap_vec = tv_base + {trap_cause[XLEN-3:0], 2'b00};
    end
  end

  assign unused_trap_pc_lsbs = ^trap_pc[1:0];
  assign mret_pc   = mepc_q;
  assign mstatus_o = mstatus_val;
  assign mcycle_o  = mcycle;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a 64-bit instance for access, trap and counter
// behaviour, and a 32-bit instance for the split counter halves.
module tb_csr_file;
  import csr_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 64-bit instance
  logic [11:0] a_addr = '0;
  logic [1:0]  a_op = '0;
  logic [63:0] a_wdata = '0;
  logic [63:0] a_rdata;
  logic        a_illegal;
  logic        a_instret_inc = 1'b0;
  logic        a_trap_valid = 1'b0;
  logic [63:0] a_trap_pc = '0;
  logic [63:0] a_trap_cause = '0;
  logic [63:0] a_trap_vec;
  logic        a_mret_valid = 1'b0;
  logic [63:0] a_mret_pc;
  logic [63:0] a_mstatus;
  logic [63:0] a_mcycle;

  // 32-bit instance
  logic [11:0] b_addr = '0;
  logic [1:0]  b_op = '0;
  logic [31:0] b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_illegal;
  logic        b_instret_inc = 1'b0;
  logic        b_trap_valid = 1'b0;
  logic [31:0] b_trap_pc = '0;
  logic [31:0] b_trap_cause = '0;
  logic [31:0] b_trap_vec;
  logic        b_mret_valid = 1'b0;
  logic [31:0] b_mret_pc;
  logic [31:0] b_mstatus;
  logic [63:0] b_mcycle;

  int n_total = 0;
  int n_bad = 0;

  csr_file #(.XLEN(64), .HART_ID(64'd5), .MTVEC_RESET(64'h100)) dut64 (
    .clk(clk), .rst(rst), .csr_addr(a_addr), .csr_op(a_op), .csr_wdata(a_wdata),
    .csr_rdata(a_rdata), .csr_illegal(a_illegal), .instret_inc(a_instret_inc),
    .trap_valid(a_trap_valid), .trap_pc(a_trap_pc), .trap_cause(a_trap_cause),
    .trap_vec(a_trap_vec), .mret_valid(a_mret_valid), .mret_pc(a_mret_pc),
    .mstatus_o(a_mstatus), .mcycle_o(a_mcycle)
  );

  csr_file #(.XLEN(32), .HART_ID(32'd0), .MTVEC_RESET(32'd0)) dut32 (
    .clk(clk), .rst(rst), .csr_addr(b_addr), .csr_op(b_op), .csr_wdata(b_wdata),
    .csr_rdata(b_rdata), .csr_illegal(b_illegal), .instret_inc(b_instret_inc),
    .trap_valid(b_trap_valid), .trap_pc(b_trap_pc), .trap_cause(b_trap_cause),
    .trap_vec(b_trap_vec), .mret_valid(b_mret_valid), .mret_pc(b_mret_pc),
    .mstatus_o(b_mstatus), .mcycle_o(b_mcycle)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input logic [11:0] a, input logic [1:0] o, input logic [63:0] w);
    a_addr = a; a_op = o; a_wdata = w;
    #1;
  endtask

  task automatic rd64(input string tag, input logic [11:0] a, input logic [63:0] exp);
    drive64(a, CSR_OP_RS, 64'h0);
    chk(tag, a_rdata, exp);
  endtask

  task automatic drive32(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w);
    b_addr = a; b_op = o; b_wdata = w;
    #1;
  endtask

  task automatic rd32(input string tag, input logic [11:0] a, input logic [31:0] exp);
    drive32(a, CSR_OP_RS, 32'h0);
    chk(tag, 64'(b_rdata), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs stay quiet while reset is held, even with an illegal op driven.
    drive64(12'h7C0, CSR_OP_RW, 64'h1);
    tick(); tick();
    chk("rst_rdata", a_rdata, 64'h0);
    chk("rst_illegal", 64'(a_illegal), 64'h0);
    rst = 1'b0;
    drive64(12'h000, CSR_OP_NONE, 64'h0);
    chk("rst_mstatus_o", a_mstatus, 64'h1800);
    chk("rst_mcycle_o", a_mcycle, 64'h0);
    chk("rst_trap_vec", a_trap_vec, 64'h100);
    rd64("rst_mstatus", CSR_MSTATUS, 64'h1800);
    rd64("rst_mtvec", CSR_MTVEC, 64'h100);
    rd64("rst_mhartid", CSR_MHARTID, 64'h5);
    chk("rst_hartid_illegal", 64'(a_illegal), 64'h0);

    // RW / RS / RC on mscratch
    drive64(CSR_MSCRATCH, CSR_OP_RW, 64'hA5);
    chk("rw_old", a_rdata, 64'h0);
    tick();
    drive64(CSR_MSCRATCH, CSR_OP_RS, 64'h0F);
    chk("rs_old", a_rdata, 64'hA5);
    tick();
    rd64("rs_new", CSR_MSCRATCH, 64'hAF);
    drive64(CSR_MSCRATCH, CSR_OP_RC, 64'hA0);
    chk("rc_old", a_rdata, 64'hAF);
    tick();
    rd64("rc_new", CSR_MSCRATCH, 64'h0F);

    // Read-only and unmapped accesses
    drive64(CSR_MHARTID, CSR_OP_RW, 64'h99);
    chk("hartid_rw_illegal", 64'(a_illegal), 64'h1);
    chk("hartid_rw_rdata", a_rdata, 64'h0);
    tick();
    rd64("hartid_kept", CSR_MHARTID, 64'h5);
    drive64(CSR_MHARTID, CSR_OP_RS, 64'h1);
    chk("hartid_rs_nz_illegal", 64'(a_illegal), 64'h1);
    tick();
    rd64("unmapped_rdata", 12'h7C0, 64'h0);
    chk("unmapped_illegal", 64'(a_illegal), 64'h1);
    drive64(CSR_MSCRATCH, CSR_OP_NONE, 64'h0);
    chk("op_none_rdata", a_rdata, 64'h0);
    chk("op_none_illegal", 64'(a_illegal), 64'h0);

    // Write masks
    drive64(CSR_MEPC, CSR_OP_RW, 64'h1234_567F);
    tick();
    rd64("mepc_mask", CSR_MEPC, 64'h1234_567C);
    drive64(CSR_MTVEC, CSR_OP_RW, 64'h7);
    tick();
    rd64("mtvec_mask", CSR_MTVEC, 64'h5);
    drive64(CSR_MSTATUS, CSR_OP_RW, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd64("mstatus_mask_ones", CSR_MSTATUS, 64'h1888);
    drive64(CSR_MSTATUS, CSR_OP_RW, 64'h0);
    tick();
    rd64("mstatus_mpp_sticky", CSR_MSTATUS, 64'h1800);
    drive64(CSR_MSTATUS, CSR_OP_RW, 64'h8);
    tick();
    rd64("mstatus_mie_set", CSR_MSTATUS, 64'h1808);

    // Trap with a concurrent CSR write that must be suppressed
    a_trap_valid = 1'b1;
    a_trap_pc = 64'h8000_0006;
    a_trap_cause = 64'hB;
    drive64(CSR_MSCRATCH, CSR_OP_RW, 64'h123);
    chk("trap_op_legal", 64'(a_illegal), 64'h0);
    tick();
    a_trap_valid = 1'b0;
    rd64("trap_mepc", CSR_MEPC, 64'h8000_0004);
    rd64("trap_mcause", CSR_MCAUSE, 64'hB);
    rd64("trap_mstatus", CSR_MSTATUS, 64'h1880);
    rd64("trap_suppressed_wr", CSR_MSCRATCH, 64'h0F);
    chk("trap_mret_pc", a_mret_pc, 64'h8000_0004);
    a_mret_valid = 1'b1;
    drive64(12'h000, CSR_OP_NONE, 64'h0);
    tick();
    a_mret_valid = 1'b0;
    rd64("mret_mstatus", CSR_MSTATUS, 64'h1888);
    chk("mret_pc_after", a_mret_pc, 64'h8000_0004);

    // Vectored trap target
    drive64(CSR_MTVEC, CSR_OP_RW, 64'h8000_0001);
    tick();
    drive64(12'h000, CSR_OP_NONE, 64'h0);
    a_trap_cause = 64'h8000_0000_0000_0007;
    #1;
    chk("trap_vec_irq", a_trap_vec, 64'h8000_001C);
    a_trap_cause = 64'h7;
    #1;
    chk("trap_vec_exc", a_trap_vec, 64'h8000_0000);

    // mcycle wrap, unmapped high half, suppressed counter write still ticks
    drive64(CSR_MCYCLE, CSR_OP_RW, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drive64(12'h000, CSR_OP_NONE, 64'h0);
    chk("mcycle_written", a_mcycle, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("mcycle_wrap", a_mcycle, 64'h0);
    rd64("mcycle_wrap_rd", CSR_MCYCLE, 64'h0);
    drive64(CSR_MCYCLEH, CSR_OP_RS, 64'h0);
    chk("mcycleh_64_illegal", 64'(a_illegal), 64'h1);
    a_mret_valid = 1'b1;
    drive64(CSR_MCYCLE, CSR_OP_RW, 64'h50);
    tick();
    a_mret_valid = 1'b0;
    drive64(12'h000, CSR_OP_NONE, 64'h0);
    chk("mcycle_suppressed_wr", a_mcycle, 64'h1);

    // minstret counting and write-wins
    a_instret_inc = 1'b1;
    repeat (5) tick();
    a_instret_inc = 1'b0;
    rd64("minstret_5", CSR_MINSTRET, 64'h5);
    a_instret_inc = 1'b1;
    drive64(CSR_MINSTRET, CSR_OP_RW, 64'h40);
    tick();
    a_instret_inc = 1'b0;
    rd64("minstret_wr_wins", CSR_MINSTRET, 64'h40);

    // Reset asserted mid-operation
    rst = 1'b1;
    a_trap_valid = 1'b1;
    drive64(CSR_MSCRATCH, CSR_OP_RW, 64'h77);
    tick();
    rst = 1'b0;
    a_trap_valid = 1'b0;
    drive64(12'h000, CSR_OP_NONE, 64'h0);
    chk("midrst_mcycle", a_mcycle, 64'h0);
    rd64("midrst_mscratch", CSR_MSCRATCH, 64'h0);
    rd64("midrst_mstatus", CSR_MSTATUS, 64'h1800);
    rd64("midrst_minstret", CSR_MINSTRET, 64'h0);
    drive64(12'h000, CSR_OP_NONE, 64'h0);

    // XLEN=32 counter halves
    rd32("x32_mstatus", CSR_MSTATUS, 32'h1800);
    rd32("x32_hartid", CSR_MHARTID, 32'h0);
    drive32(CSR_MCYCLE, CSR_OP_RW, 32'h10);
    tick();
    drive32(CSR_MCYCLEH, CSR_OP_RW, 32'h1);
    chk("x32_mcycleh_old", 64'(b_rdata), 64'h0);
    tick();
    drive32(12'h000, CSR_OP_NONE, 32'h0);
    chk("x32_hi_write", b_mcycle, 64'h1_0000_0010);
    rd32("x32_mcycleh_rd", CSR_MCYCLEH, 32'h1);
    rd32("x32_mcycle_rd", CSR_MCYCLE, 32'h10);
    drive32(CSR_MCYCLE, CSR_OP_RW, 32'hFFFF_FFFF);
    tick();
    drive32(12'h000, CSR_OP_NONE, 32'h0);
    chk("x32_lo_write", b_mcycle, 64'h1_FFFF_FFFF);
    tick();
    chk("x32_carry", b_mcycle, 64'h2_0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
